dmem_store_buffer: RTL and testbench
====================================

Name: dmem_store_buffer

Overview:
- Posted-write buffer directly downstream of cpu_main's data port.
- Captures every store the single-cycle core issues (MemWrite, DataAdr, WriteData) into a FIFO, then drains the stores in order to data memory over a valid/ready handshake.
- Forwards buffered data to core loads whose address matches a pending store, so the core always sees its own writes.
- Stalls the core when the buffer is full.

Parameters:
- DEPTH, 4, number of store entries; power of two, at least 2.
- AW, 32, address width.
- DW, 32, data width.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- MemWrite  input  1  store request from the core this cycle.
- DataAdr  input  AW  store address (byte address, word-aligned).
- WriteData  input  DW  store data.
- RdAdr  input  AW  core load address used for the forwarding lookup.
- RdHit  output  1  a buffered store matches RdAdr (combinational).
- RdData  output  DW  data of the youngest matching entry; 0 when RdHit is 0.
- Stall  output  1  store refused this cycle; the core must hold its PC and the store.
- mem_wvalid  output  1  head entry is presented to memory.
- mem_wready  input  1  memory accepts the head entry this cycle.
- mem_waddr  output  AW  head entry address.
- mem_wdata  output  DW  head entry data.
- Count  output  clog2(DEPTH)+1  number of occupied entries.
- Empty  output  1  Count equals 0.

Behaviour:
- State:
  - Entry arrays addr[DEPTH] and data[DEPTH].
  - Write pointer wp, read pointer rp, each clog2(DEPTH) bits, wrapping modulo DEPTH.
  - Count register.
- Reset (asynchronous, immediate):
  - wp=0, rp=0, Count=0, so Empty=1, mem_wvalid=0, Stall=0, RdHit=0, RdData=0.
  - Entry contents are not reset.
  - Reset mid-drain discards all pending stores. The memory side must tolerate a dropped handshake.
- Push:
  - push = MemWrite & (Count != DEPTH).
  - On push: addr[wp] <= DataAdr, data[wp] <= WriteData, wp <= wp+1.
- Stall:
  - Stall = MemWrite & (Count == DEPTH), combinational.
  - Stall depends only on registered Count, never on mem_wready. This keeps the memory handshake out of the core's critical path.
  - A full buffer refuses a push even when a pop occurs the same cycle. The store is accepted on the next cycle.
- Pop:
  - mem_wvalid = (Count != 0). mem_waddr = addr[rp], mem_wdata = data[rp].
  - pop = mem_wvalid & mem_wready; on pop, rp <= rp+1.
  - mem_wvalid, mem_waddr and mem_wdata stay stable until the pop. mem_wvalid never drops without a pop, except on reset.
- Count update:
  - push only: Count+1.
  - pop only: Count-1.
  - push and pop in the same cycle: Count unchanged.
  - neither: unchanged.
- Latency:
  - A store pushed at edge N is visible on mem_wvalid after edge N; earliest memory acceptance is edge N+1.
  - There is no empty-buffer bypass.
- Ordering: strict FIFO; memory receives stores in issue order.
- Forwarding (combinational, over occupied entries only):
  - An entry matches when addr[i][AW-1:2] == RdAdr[AW-1:2]; bits [1:0] are ignored.
  - The youngest matching entry (closest to wp-1) wins.
  - A store being pushed in the current cycle is not forwarded.
  - An entry popping this cycle is still forwardable this cycle.
- Wrap-around: pointer wrap DEPTH-1 -> 0 is seamless; Count alone distinguishes full from empty.

Test Plan:
- Single store, immediate drain: after reset, MemWrite=1, DataAdr=20, WriteData=2 for one cycle, mem_wready=1 -> next cycle mem_wvalid=1, mem_waddr=20, mem_wdata=2; following edge Count=0, Empty=1.
- Fill and stall: mem_wready=0, push addr 0,4,8,12 with data 1..4 -> Count=4. Fifth store to 16 -> Stall=1, no push. Raise mem_wready for one cycle -> Count=3 with Stall still 1 that cycle; next cycle the store is accepted, Count=4.
- Ordering with wrap: push 6 stores (addr 0x40+4k, data k) while toggling mem_wready -> memory side receives data 0,1,2,3,4,5 in order across pointer wrap.
- Forwarding youngest: mem_wready=0, push (0x100,0xA), (0x104,0xB), (0x100,0xC); RdAdr=0x102 -> RdHit=1, RdData=0xC. RdAdr=0x108 -> RdHit=0, RdData=0.
- Simultaneous push/pop: Count=2, MemWrite=1 and mem_wready=1 same cycle -> Count stays 2, head advances, new entry at tail.
- Reset mid-operation: Count=3 with mem_wvalid=1, assert reset between edges -> mem_wvalid, Count and RdHit go to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/dmem_store_buffer.sv
// dmem_store_buffer: posted-write FIFO between the core's data port and data
// memory. It captures core stores, drains them in order over a valid/ready
// handshake, and forwards buffered data to core loads that hit a pending store.
module dmem_store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       MemWrite,
  input  logic [AW-1:0]              DataAdr,
  input  logic [DW-1:0]              WriteData,
  input  logic [AW-1:0]              RdAdr,
  output logic                       RdHit,
  output logic [DW-1:0]              RdData,
  output logic                       Stall,
  output logic                       mem_wvalid,
  input  logic                       mem_wready,
  output logic [AW-1:0]              mem_waddr,
  output logic [DW-1:0]              mem_wdata,
  output logic [$clog2(DEPTH):0]     Count,
  output logic                       Empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Entry storage carries data only; occupancy is tracked by the pointers and count.
  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];

  logic [PW-1:0] wp;
  logic [PW-1:0] rp;
  logic [CW-1:0] count;

  logic full;
  logic push;
  logic pop;

  // A full buffer refuses the store even if the head drains this cycle, so
  // Stall depends only on registered state and never on mem_wready.
  assign full       = (count == CW'(DEPTH));
  assign push       = MemWrite & ~full;
  assign Stall      = MemWrite & full;
  assign mem_wvalid = (count != '0);
  assign pop        = mem_wvalid & mem_wready;
  assign mem_waddr  = addr_q[rp];
  assign mem_wdata  = data_q[rp];
  assign Count      = count;
  assign Empty      = (count == '0);

  // Control state: pointers wrap modulo DEPTH, count separates full from empty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + PW'(1);
      if (pop)  rp <= rp + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry write on an accepted store; contents are left untouched by reset.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wp] <= DataAdr;
      data_q[wp] <= WriteData;
    end
  end

  // Forwarding walks occupied entries oldest to youngest so the youngest
  // word-address match is the one left standing; the head is still eligible
  // while it pops, and a store being pushed this cycle is not yet visible.
  logic          hit;
  logic [DW-1:0] hdata;
  logic [PW-1:0] fidx;

  always_comb begin
    hit   = 1'b0;
    hdata = '0;
    fidx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      fidx = rp + PW'(i);
      if ((CW'(i) < count) && (addr_q[fidx][AW-1:2] == RdAdr[AW-1:2])) begin
        hit   = 1'b1;
        hdata = data_q[fidx];
      end
    end
  end

  assign RdHit  = hit;
  assign RdData = hdata;

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Bench for dmem_store_buffer: queue-based reference model compared every
// cycle, plus directed scenarios with literal expectations.
module tb_dmem_store_buffer;

  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          MemWrite;
  logic [AW-1:0] DataAdr;
  logic [DW-1:0] WriteData;
  logic [AW-1:0] RdAdr;
  logic          RdHit;
  logic [DW-1:0] RdData;
  logic          Stall;
  logic          mem_wvalid;
  logic          mem_wready;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;
  logic [2:0]    Count;
  logic          Empty;

  dmem_store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk        (clk),
    .reset      (reset),
    .MemWrite   (MemWrite),
    .DataAdr    (DataAdr),
    .WriteData  (WriteData),
    .RdAdr      (RdAdr),
    .RdHit      (RdHit),
    .RdData     (RdData),
    .Stall      (Stall),
    .mem_wvalid (mem_wvalid),
    .mem_wready (mem_wready),
    .mem_waddr  (mem_waddr),
    .mem_wdata  (mem_wdata),
    .Count      (Count),
    .Empty      (Empty)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  ent_t          q[$];
  logic [DW-1:0] rx[$];
  int            ncmp  = 0;
  int            nfail = 0;
  bit            chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue; memory takes the front, core appends at the back.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q.delete();
    end else begin
      bit do_push;
      bit do_pop;
      do_push = MemWrite && (q.size() < DEPTH);
      do_pop  = (q.size() != 0) && mem_wready;
      if (do_pop)  void'(q.pop_front());
      if (do_push) q.push_back('{a: DataAdr, d: WriteData});
    end
  end

  // Youngest pending store whose word address matches the load address.
  function automatic void model_fwd(output bit hit, output logic [DW-1:0] d);
    hit = 1'b0;
    d   = '0;
    for (int i = int'(q.size()) - 1; i >= 0; i--) begin
      if (q[i].a[AW-1:2] == RdAdr[AW-1:2]) begin
        hit = 1'b1;
        d   = q[i].d;
        break;
      end
    end
  endfunction

  // Per-cycle comparison against the model, sampled away from the clock edge.
  always @(negedge clk) begin
    if (chk_en) begin
      bit            eh;
      logic [DW-1:0] ed;
      model_fwd(eh, ed);
      chk("count",  Count, q.size());
      chk("empty",  Empty, q.size() == 0);
      chk("wvalid", mem_wvalid, q.size() != 0);
      if (q.size() != 0) begin
        chk("waddr", mem_waddr, q[0].a);
        chk("wdata", mem_wdata, q[0].d);
      end
      chk("stall",  Stall, MemWrite && (q.size() == DEPTH));
      chk("rdhit",  RdHit, eh);
      chk("rddata", RdData, ed);
      if (mem_wvalid && mem_wready) rx.push_back(mem_wdata);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    mem_wready = 1'b1;
    MemWrite   = 1'b0;
    for (int n = 0; n < 20 && !Empty; n++) tick();
    chk("drain_done", Empty, 1'b1);
    mem_wready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; MemWrite = 1'b0; DataAdr = '0; WriteData = '0;
    RdAdr = '0; mem_wready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk_en = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_empty", Empty, 1'b1);
    chk("rst_count", Count, 3'd0);
    chk("rst_wvalid", mem_wvalid, 1'b0);
    chk("rst_rdhit", RdHit, 1'b0);
    tick();

    // Single store, immediate drain
    MemWrite = 1'b1; DataAdr = 32'd20; WriteData = 32'd2; mem_wready = 1'b1;
    tick();
    MemWrite = 1'b0;
    @(negedge clk);
    chk("t1_wvalid", mem_wvalid, 1'b1);
    chk("t1_waddr", mem_waddr, 32'd20);
    chk("t1_wdata", mem_wdata, 32'd2);
    tick();
    @(negedge clk);
    chk("t1_count", Count, 3'd0);
    chk("t1_empty", Empty, 1'b1);
    tick();

    // Fill and stall
    rx.delete();
    mem_wready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      MemWrite = 1'b1; DataAdr = 32'(4 * k); WriteData = 32'(k + 1);
      tick();
    end
    DataAdr = 32'd16; WriteData = 32'd5;
    @(negedge clk);
    chk("t2_full_count", Count, 3'd4);
    chk("t2_stall", Stall, 1'b1);
    tick();
    mem_wready = 1'b1;
    @(negedge clk);
    chk("t2_stall_pop", Stall, 1'b1);
    chk("t2_head", mem_waddr, 32'd0);
    tick();
    mem_wready = 1'b0;
    @(negedge clk);
    chk("t2_after_pop", Count, 3'd3);
    chk("t2_accept", Stall, 1'b0);
    tick();
    MemWrite = 1'b0;
    @(negedge clk);
    chk("t2_refill", Count, 3'd4);
    tick();
    drain();
    chk("t2_rx_n", rx.size(), 5);
    if (rx.size() == 5)
      for (int k = 0; k < 5; k++) chk("t2_rx", rx[k], 32'(k + 1));

    // Ordering across pointer wrap
    rx.delete();
    for (int k = 0; k < 6; k++) begin
      MemWrite = 1'b1; DataAdr = 32'h40 + 32'(4 * k); WriteData = 32'(k);
      mem_wready = k[0];
      tick();
    end
    drain();
    chk("t3_rx_n", rx.size(), 6);
    if (rx.size() == 6)
      for (int k = 0; k < 6; k++) chk("t3_rx", rx[k], 32'(k));

    // Forwarding picks the youngest match
    MemWrite = 1'b1; DataAdr = 32'h100; WriteData = 32'hA; tick();
    DataAdr = 32'h104; WriteData = 32'hB; tick();
    DataAdr = 32'h100; WriteData = 32'hC; tick();
    MemWrite = 1'b0; RdAdr = 32'h102;
    @(negedge clk);
    chk("t4_hit", RdHit, 1'b1);
    chk("t4_data", RdData, 32'hC);
    tick();
    RdAdr = 32'h108;
    @(negedge clk);
    chk("t4_miss", RdHit, 1'b0);
    chk("t4_miss_data", RdData, 32'h0);
    tick();
    MemWrite = 1'b1; DataAdr = 32'h108; WriteData = 32'hD;
    @(negedge clk);
    chk("t4_no_fwd_push", RdHit, 1'b0);
    tick();
    MemWrite = 1'b0; RdAdr = 32'h10B;
    @(negedge clk);
    chk("t4_tail_hit", RdData, 32'hD);
    tick();
    mem_wready = 1'b1; RdAdr = 32'h104;
    tick();
    @(negedge clk);
    chk("t4_pop_fwd_hit", RdHit, 1'b1);
    chk("t4_pop_fwd_data", RdData, 32'hB);
    tick();

    // Simultaneous push and pop
    MemWrite = 1'b1; DataAdr = 32'h200; WriteData = 32'hE; mem_wready = 1'b1;
    @(negedge clk);
    chk("t5_count_pre", Count, 3'd2);
    tick();
    MemWrite = 1'b0; mem_wready = 1'b0; RdAdr = 32'h200;
    @(negedge clk);
    chk("t5_count", Count, 3'd2);
    chk("t5_head", mem_waddr, 32'h108);
    chk("t5_tail", RdData, 32'hE);
    tick();

    // Reset mid-operation
    drain();
    for (int k = 0; k < 3; k++) begin
      MemWrite = 1'b1; DataAdr = 32'h300 + 32'(4 * k); WriteData = 32'h30 + 32'(k);
      tick();
    end
    MemWrite = 1'b0; RdAdr = 32'h304;
    @(negedge clk);
    chk("t6_count", Count, 3'd3);
    chk("t6_hit", RdData, 32'h31);
    #2 reset = 1'b1;
    #1;
    chk("t6_rst_wvalid", mem_wvalid, 1'b0);
    chk("t6_rst_count", Count, 3'd0);
    chk("t6_rst_rdhit", RdHit, 1'b0);
    chk("t6_rst_empty", Empty, 1'b1);
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("t6_post_empty", Empty, 1'b1);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
